// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and constants for the LED pattern sequencer.
//   mode_t     : pattern mode, encoding equals the value driven on mode_o
//   SEED_*     : pattern value loaded when the corresponding mode is entered
//   next_mode  : mode cycling order UP -> DOWN -> SHIFT -> BLINK -> UP
//   seed_of    : seed lookup for a given mode
// -----------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        SHIFT = 2'd2,
        BLINK = 2'd3
    } mode_t;

    localparam logic [5:0] SEED_UP    = 6'h00;
    localparam logic [5:0] SEED_DOWN  = 6'h3F;
    localparam logic [5:0] SEED_SHIFT = 6'h01;
    localparam logic [5:0] SEED_BLINK = 6'h00;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            UP:      next_mode = DOWN;
            DOWN:    next_mode = SHIFT;
            SHIFT:   next_mode = BLINK;
            default: next_mode = UP;
        endcase
    endfunction

    function automatic logic [5:0] seed_of(input mode_t m);
        case (m)
            UP:      seed_of = SEED_UP;
            DOWN:    seed_of = SEED_DOWN;
            SHIFT:   seed_of = SEED_SHIFT;
            default: seed_of = SEED_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl_if
// Bundle of the sequencer's button inputs and LED/status outputs.
//   mode_i, pause_i : debounced button levels (driven by the master side)
//   led_o           : active-low LED drive
//   mode_o          : current mode encoding
//   running_o       : 1 = stepping, 0 = held
// modport master : the side that drives the buttons and observes the outputs
// modport slave  : the sequencer side
// -----------------------------------------------------------------------------
interface led_seq_ctrl_if;
    import led_seq_pkg::*;

    logic       mode_i;
    logic       pause_i;
    logic [5:0] led_o;
    logic [1:0] mode_o;
    logic       running_o;

    modport master (
        output mode_i,
        output pause_i,
        input  led_o,
        input  mode_o,
        input  running_o
    );

    modport slave (
        input  mode_i,
        input  pause_i,
        output led_o,
        output mode_o,
        output running_o
    );

endinterface

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Free-running prescaler producing a one-cycle step pulse every COUNT cycles.
//   clk    : system clock
//   rst    : synchronous active-low reset (counter -> 0)
//   en_i   : count enable; while low the counter holds and tick_o stays low
//   clr_i  : synchronous clear to 0 (takes priority over counting)
//   tick_o : high for one cycle while the counter sits at COUNT-1 and en_i=1
// -----------------------------------------------------------------------------
module led_tick_gen #(
    parameter int COUNT = 13500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = $clog2(COUNT);
    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == LAST);
    assign tick_o  = en_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// Six-LED pattern sequencer with four modes and a run/hold toggle.
//   COUNT     : clk cycles per pattern step (>= 2)
//   clk       : system clock
//   rst       : synchronous active-low reset
//   mode_i    : debounced button, each rising edge advances the mode
//   pause_i   : debounced button, each rising edge toggles run/hold
//   led_o     : active-low LED drive (inverse of the pattern register)
//   mode_o    : current mode (UP=0, DOWN=1, SHIFT=2, BLINK=3)
//   running_o : 1 = stepping, 0 = held
// -----------------------------------------------------------------------------
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int COUNT = 13500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_i,
    input  logic       pause_i,
    output logic [5:0] led_o,
    output logic [1:0] mode_o,
    output logic       running_o
);

    mode_t      state_q, state_d;
    logic [5:0] pattern_q, pattern_d;
    logic [5:0] led_q, led_d;
    logic       running_q, running_d;
    logic       mode_dly_q, mode_dly_d;
    logic       pause_dly_q, pause_dly_d;

    logic       mode_ev;
    logic       pause_ev;
    logic       step;

    // Edge detect against the previous-cycle level; a held level fires once.
    assign mode_ev  = mode_i  && !mode_dly_q;
    assign pause_ev = pause_i && !pause_dly_q;

    // A mode change restarts the step spacing from zero.
    led_tick_gen #(
        .COUNT (COUNT)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (running_q),
        .clr_i  (mode_ev),
        .tick_o (step)
    );

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        running_d   = running_q;
        mode_dly_d  = mode_i;
        pause_dly_d = pause_i;

        if (mode_ev) begin
            // Mode change wins over a coincident step: seed, not stepped value.
            state_d   = next_mode(state_q);
            pattern_d = seed_of(next_mode(state_q));
        end else if (step) begin
            case (state_q)
                UP:      pattern_d = pattern_q + 6'd1;
                DOWN:    pattern_d = pattern_q - 6'd1;
                SHIFT:   pattern_d = {pattern_q[4:0], pattern_q[5]};
                default: pattern_d = ~pattern_q;
            endcase
        end

        if (pause_ev) begin
            running_d = !running_q;
        end

        // LED register tracks the pattern register exactly, so no extra latency.
        led_d = ~pattern_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= UP;
            pattern_q   <= SEED_UP;
            led_q       <= ~SEED_UP;
            running_q   <= 1'b1;
            mode_dly_q  <= 1'b0;
            pause_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            led_q       <= led_d;
            running_q   <= running_d;
            mode_dly_q  <= mode_dly_d;
            pause_dly_q <= pause_dly_d;
        end
    end

    assign led_o     = led_q;
    assign mode_o    = state_q;
    assign running_o = running_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
// Bench for led_seq_ctrl with COUNT=4. A cycle model predicts the outputs of
// every clock; predictions are queued when the inputs are driven and popped
// after the edge. A vector table with hand-derived values checks the
// scenario end points, and prints one line per checked group.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_seq_ctrl;
    import led_seq_pkg::*;

    localparam int COUNT = 4;

    logic clk;
    logic rst;

    led_seq_ctrl_if bus ();

    led_seq_ctrl #(
        .COUNT (COUNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_i    (bus.mode_i),
        .pause_i   (bus.pause_i),
        .led_o     (bus.led_o),
        .mode_o    (bus.mode_o),
        .running_o (bus.running_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] led;
        logic [1:0] mode;
        logic       run;
    } exp_t;

    typedef struct {
        int         rep;
        logic       m;
        logic       p;
        logic       r;
        logic [5:0] led;
        logic [1:0] mode;
        logic       run;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int         m_cnt;
    logic [5:0] m_pat;
    logic [1:0] m_mode;
    logic       m_run;
    logic       m_md;
    logic       m_pd;

    function automatic logic [5:0] m_seed(input logic [1:0] md);
        case (md)
            2'd1:    return 6'h3F;
            2'd2:    return 6'h01;
            default: return 6'h00;
        endcase
    endfunction

    task automatic model_edge(input logic m, input logic p, input logic r);
        logic mev, pev, stp;
        exp_t e;
        if (!r) begin
            m_cnt = 0; m_pat = 6'h00; m_mode = 2'd0;
            m_run = 1'b1; m_md = 1'b0; m_pd = 1'b0;
        end else begin
            mev = m && !m_md;
            pev = p && !m_pd;
            stp = m_run && (m_cnt == COUNT - 1);
            if (mev) begin
                m_mode = m_mode + 2'd1;
                m_pat  = m_seed(m_mode);
                m_cnt  = 0;
            end else begin
                if (stp) begin
                    case (m_mode)
                        2'd0: m_pat = 6'((int'(m_pat) + 1) % 64);
                        2'd1: m_pat = 6'((int'(m_pat) + 63) % 64);
                        2'd2: m_pat = 6'(((int'(m_pat) * 2) % 64) + (int'(m_pat) / 32));
                        default: m_pat = 6'(63 - int'(m_pat));
                    endcase
                end
                if (m_run) m_cnt = (m_cnt + 1) % COUNT;
            end
            if (pev) m_run = !m_run;
            m_md = m;
            m_pd = p;
        end
        e.led  = 6'(63 - int'(m_pat));
        e.mode = m_mode;
        e.run  = m_run;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic m, input logic p, input logic r);
        exp_t e;
        @(negedge clk);
        bus.mode_i  = m;
        bus.pause_i = p;
        rst         = r;
        model_edge(m, p, r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.led_o !== e.led || bus.mode_o !== e.mode || bus.running_o !== e.run) begin
            n_fail++;
            $display("FAIL cycle t=%0t got led=%h mode=%0d run=%b required led=%h mode=%0d run=%b",
                     $time, bus.led_o, bus.mode_o, bus.running_o, e.led, e.mode, e.run);
        end
    endtask

    function automatic void add(input int rep, input logic m, input logic p, input logic r,
                                input logic [5:0] led, input logic [1:0] mode, input logic run);
        vec_t v;
        v.rep = rep; v.m = m; v.p = p; v.r = r;
        v.led = led; v.mode = mode; v.run = run;
        vecs.push_back(v);
    endfunction

    initial begin
        bus.mode_i  = 1'b0;
        bus.pause_i = 1'b0;
        rst         = 1'b0;

        // rep, mode, pause, rst, led, mode, run
        // reset state and UP counting, one step every 4 cycles
        add(2,   0, 0, 0, 6'h3F, 2'd0, 1);
        add(3,   0, 0, 1, 6'h3F, 2'd0, 1);
        add(1,   0, 0, 1, 6'h3E, 2'd0, 1);
        add(4,   0, 0, 1, 6'h3D, 2'd0, 1);
        add(4,   0, 0, 1, 6'h3C, 2'd0, 1);
        add(4,   0, 0, 1, 6'h3B, 2'd0, 1);
        // run up to pattern 3F, then wrap to 00
        add(236, 0, 0, 1, 6'h00, 2'd0, 1);
        add(4,   0, 0, 1, 6'h3F, 2'd0, 1);
        // three mode pulses: DOWN 3F, SHIFT 01, BLINK 00
        add(1,   1, 0, 1, 6'h00, 2'd1, 1);
        add(1,   0, 0, 1, 6'h00, 2'd1, 1);
        add(1,   1, 0, 1, 6'h3E, 2'd2, 1);
        add(1,   0, 0, 1, 6'h3E, 2'd2, 1);
        add(1,   1, 0, 1, 6'h3F, 2'd3, 1);
        add(1,   0, 0, 1, 6'h3F, 2'd3, 1);
        // back round to SHIFT
        add(1,   1, 0, 1, 6'h3F, 2'd0, 1);
        add(1,   0, 0, 1, 6'h3F, 2'd0, 1);
        add(1,   1, 0, 1, 6'h00, 2'd1, 1);
        add(1,   0, 0, 1, 6'h00, 2'd1, 1);
        add(1,   1, 0, 1, 6'h3E, 2'd2, 1);
        // SHIFT: first step 01->02, then to 20, then wrap 20->01
        add(4,   0, 0, 1, 6'h3D, 2'd2, 1);
        add(16,  0, 0, 1, 6'h1F, 2'd2, 1);
        add(4,   0, 0, 1, 6'h3E, 2'd2, 1);
        // mode pulse aligned with prescaler=3: seed wins, spacing restarts
        add(3,   0, 0, 1, 6'h3E, 2'd2, 1);
        add(1,   1, 0, 1, 6'h3F, 2'd3, 1);
        add(3,   0, 0, 1, 6'h3F, 2'd3, 1);
        add(1,   0, 0, 1, 6'h00, 2'd3, 1);
        // pause, hold 20 cycles, resume: step 2 cycles after the second pulse
        add(1,   0, 0, 1, 6'h00, 2'd3, 1);
        add(1,   0, 1, 1, 6'h00, 2'd3, 0);
        add(20,  0, 0, 1, 6'h00, 2'd3, 0);
        add(1,   0, 1, 1, 6'h00, 2'd3, 1);
        add(1,   0, 0, 1, 6'h00, 2'd3, 1);
        add(1,   0, 0, 1, 6'h3F, 2'd3, 1);
        // mode held 50 cycles: single advance to UP, then 12 steps -> 0C
        add(50,  1, 0, 1, 6'h33, 2'd0, 1);
        add(1,   0, 0, 1, 6'h33, 2'd0, 1);
        // into BLINK, step, pause, then reset with buttons pressed
        add(1,   1, 0, 1, 6'h00, 2'd1, 1);
        add(1,   0, 0, 1, 6'h00, 2'd1, 1);
        add(1,   1, 0, 1, 6'h3E, 2'd2, 1);
        add(1,   0, 0, 1, 6'h3E, 2'd2, 1);
        add(1,   1, 0, 1, 6'h3F, 2'd3, 1);
        add(4,   0, 0, 1, 6'h00, 2'd3, 1);
        add(1,   0, 1, 1, 6'h00, 2'd3, 0);
        add(3,   0, 0, 1, 6'h00, 2'd3, 0);
        add(1,   1, 1, 0, 6'h3F, 2'd0, 1);
        // buttons held through release: one event each on first clock
        add(1,   1, 1, 1, 6'h00, 2'd1, 0);
        add(2,   1, 1, 1, 6'h00, 2'd1, 0);
        add(2,   0, 0, 1, 6'h00, 2'd1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].rep; k++) begin
                cycle(vecs[i].m, vecs[i].p, vecs[i].r);
            end
            n_checks++;
            if (bus.led_o !== vecs[i].led || bus.mode_o !== vecs[i].mode ||
                bus.running_o !== vecs[i].run) begin
                n_fail++;
                $display("FAIL vec%0d got led=%h mode=%0d run=%b required led=%h mode=%0d run=%b",
                         i, bus.led_o, bus.mode_o, bus.running_o,
                         vecs[i].led, vecs[i].mode, vecs[i].run);
            end else begin
                $display("vec%0d ok led=%h mode=%0d run=%b", i, bus.led_o, bus.mode_o, bus.running_o);
            end
        end

        // Random button activity with occasional reset, checked by the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) != 0));
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
